// File: rtl/lzd_norm_pipe.sv
// Two-stage leading-zero count and normalise pipeline with valid/ready handshake.
// Define LZD_NORM_SHIFT_EN to build the stage-2 barrel shifter; otherwise out_norm is 0.
module lzd_norm_pipe #(
  parameter int WIDTH = 48,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_lzc,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [15:0]      zero_cnt
);

  localparam int LG  = $clog2(WIDTH);
  localparam int P   = 1 << LG;
  localparam int PAD = P - WIDTH;

  logic             adv;
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_data_reg;
  logic [P-1:0]     pad;
  logic             tree_v;
  logic [LG-1:0]    tree_c;
  logic [CW-1:0]    lzc_next;
  logic             zero_next;
  logic [WIDTH-1:0] norm_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Trailing ones stop the count at WIDTH for an all-zero operand.
  if (PAD > 0) begin : g_pad
    assign pad = {s1_data_reg, {PAD{1'b1}}};
  end else begin : g_nopad
    assign pad = s1_data_reg;
  end

  // Level gi holds P>>gi nodes, node 0 on the MSB side, each a gi-bit count plus valid.
  for (genvar gi = 1; gi <= LG; gi++) begin : lvl
    localparam int N = P >> gi;
    logic [N-1:0]    v;
    logic [gi*N-1:0] c;
    for (genvar ni = 0; ni < N; ni++) begin : node
      if (gi == 1) begin : g_leaf
        assign v[ni] = pad[P-1-2*ni] | pad[P-2-2*ni];
        assign c[ni] = ~pad[P-1-2*ni];
      end else begin : g_merge
        logic          vl;
        logic          vr;
        logic [gi-2:0] cl;
        logic [gi-2:0] cr;
        assign vl = lvl[gi-1].v[2*ni];
        assign vr = lvl[gi-1].v[2*ni+1];
        assign cl = lvl[gi-1].c[(2*ni)*(gi-1) +: (gi-1)];
        assign cr = lvl[gi-1].c[(2*ni+1)*(gi-1) +: (gi-1)];
        assign v[ni]          = vl | vr;
        assign c[ni*gi +: gi] = vl ? {1'b0, cl} : {1'b1, cr};
      end
    end
  end

  assign tree_v    = lvl[LG].v[0];
  assign tree_c    = lvl[LG].c[LG-1:0];
  assign lzc_next  = tree_v ? {1'b0, tree_c} : CW'(P);
  assign zero_next = ~|s1_data_reg;

`ifdef LZD_NORM_SHIFT_EN
  always_comb begin
    norm_next = s1_data_reg;
    for (int i = 0; i < LG; i++) begin
      if (lzc_next[i]) norm_next = norm_next << (1 << i);
    end
  end
`else
  assign norm_next = '0;
`endif

  always_ff @(posedge clk) begin
    if (adv) s1_data_reg <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      out_valid    <= 1'b0;
      out_lzc      <= '0;
      out_zero     <= 1'b0;
      out_norm     <= '0;
      zero_cnt     <= '0;
    end else begin
      if (adv) begin
        s1_valid_reg <= in_valid;
        out_valid    <= s1_valid_reg;
        out_lzc      <= lzc_next;
        out_zero     <= zero_next;
        out_norm     <= norm_next;
      end
      if (in_valid && adv && (in_data == '0) && (zero_cnt != 16'hFFFF))
        zero_cnt <= zero_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Bench for lzd_norm_pipe: WIDTH=8 and WIDTH=48 instances, queue-based reference model
// plus directed vectors with literal expectations.
module tb_lzd_norm_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef LZD_NORM_SHIFT_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic        v8 = 0, r8 = 1, rdy8, ov8, oz8;
  logic [7:0]  d8 = 0, on8;
  logic [3:0]  ol8;
  logic [15:0] zc8;
  logic        v48 = 0, r48 = 1, rdy48, ov48, oz48;
  logic [47:0] d48 = 0, on48;
  logic [6:0]  ol48;
  logic [15:0] zc48;

  lzd_norm_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .out_valid(ov8), .out_ready(r8), .out_lzc(ol8), .out_zero(oz8),
    .out_norm(on8), .zero_cnt(zc8));

  lzd_norm_pipe #(.WIDTH(48)) u48 (
    .clk(clk), .rst(rst), .in_valid(v48), .in_ready(rdy48), .in_data(d48),
    .out_valid(ov48), .out_ready(r48), .out_lzc(ol48), .out_zero(oz48),
    .out_norm(on48), .zero_cnt(zc48));

  typedef struct {
    int          lzc;
    bit          zero;
    logic [63:0] norm;
    int          t;
  } exp_t;

  exp_t q8[$];
  exp_t q48[$];
  int   zm8 = 0, zm48 = 0, cyc = 0;
  int   total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: scan from the MSB for the first one; normalise by plain shifting.
  function automatic exp_t model(input logic [63:0] d, input int w, input int t);
    exp_t e;
    bit   found = 0;
    logic [63:0] mask;
    e.lzc = w;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i] && !found) begin
        e.lzc = w - 1 - i;
        found = 1;
      end
    end
    mask   = (64'd1 << w) - 64'd1;
    e.zero = (d == 64'd0);
    e.norm = SH ? ((d << e.lzc) & mask) : 64'd0;
    e.t    = t;
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        q8.delete();
        q48.delete();
        zm8  = 0;
        zm48 = 0;
      end else begin
        if (ov8 && r8 && q8.size() > 0) void'(q8.pop_front());
        if (ov48 && r48 && q48.size() > 0) void'(q48.pop_front());
        if (v8 && rdy8) begin
          q8.push_back(model({56'd0, d8}, 8, cyc));
          if (d8 == 8'd0 && zm8 < 65535) zm8++;
        end
        if (v48 && rdy48) begin
          q48.push_back(model({16'd0, d48}, 48, cyc));
          if (d48 == 48'd0 && zm48 < 65535) zm48++;
        end
      end
    end
  end

  task automatic cmp(input int w, input logic ov, input logic rdy, input logic ordy,
                     input int lzc, input logic oz, input logic [63:0] norm,
                     input logic [15:0] zc);
    exp_t e;
    int   n;
    n = (w == 8) ? q8.size() : q48.size();
    chk($sformatf("w%0d in_ready", w), {63'd0, rdy}, {63'd0, (!ov || ordy)});
    chk($sformatf("w%0d zero_cnt", w), {48'd0, zc}, (w == 8) ? zm8 : zm48);
    if (n > 0) e = (w == 8) ? q8[0] : q48[0];
    if (ov) begin
      total++;
      if (n == 0) begin
        bad++;
        $display("FAIL w%0d stale: got out_valid=1 want no result pending", w);
      end else begin
        chk($sformatf("w%0d lzc", w), lzc, e.lzc);
        chk($sformatf("w%0d zero", w), {63'd0, oz}, {63'd0, e.zero});
        chk($sformatf("w%0d norm", w), norm, e.norm);
      end
    end else if (n > 0) begin
      total++;
      if (cyc >= e.t + 1) begin
        bad++;
        $display("FAIL w%0d late: got out_valid=0 want 1 (transfer cycle %0d)", w, e.t);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cmp(8, ov8, rdy8, r8, int'(ol8), oz8, {56'd0, on8}, zc8);
      cmp(48, ov48, rdy48, r48, int'(ol48), oz48, {16'd0, on48}, zc48);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] vec8 [0:3] = '{8'h13, 8'h80, 8'h01, 8'h00};
  int         lz8  [0:3] = '{3, 0, 7, 8};
  logic [7:0] nm8  [0:3] = '{8'h98, 8'h80, 8'h80, 8'h00};
  logic [7:0] st8  [0:2] = '{8'h40, 8'h05, 8'h00};

  initial begin
    int  idx;
    bit  acc;
    @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", {63'd0, rdy8}, 64'd1);
    chk("reset out_valid", {63'd0, ov8}, 64'd0);
    chk("reset zero_cnt", {48'd0, zc8}, 64'd0);
    step();
    rst = 0;
    step();

    // Back-to-back 8-bit vectors, results on cycles +2..+5.
    for (int i = 0; i < 6; i++) begin
      v8 = (i < 4);
      d8 = (i < 4) ? vec8[i] : 8'h00;
      @(negedge clk);
      if (i >= 2) begin
        chk("vec valid", {63'd0, ov8}, 64'd1);
        chk("vec lzc", {60'd0, ol8}, lz8[i-2]);
        chk("vec zero", {63'd0, oz8}, (i == 5) ? 64'd1 : 64'd0);
        chk("vec norm", {56'd0, on8}, SH ? {56'd0, nm8[i-2]} : 64'd0);
      end
      if (i == 3) chk("vec zero_cnt before", {48'd0, zc8}, 64'd0);
      if (i == 5) chk("vec zero_cnt after", {48'd0, zc8}, 64'd1);
      step();
    end
    v8 = 0;

    // 48-bit single operand, exact two-cycle latency.
    v48 = 1;
    d48 = 48'h0000_0000_0001;
    step();
    v48 = 0;
    @(negedge clk);
    chk("w48 early valid", {63'd0, ov48}, 64'd0);
    step();
    @(negedge clk);
    chk("w48 valid", {63'd0, ov48}, 64'd1);
    chk("w48 lzc", {57'd0, ol48}, 64'd47);
    chk("w48 norm", {16'd0, on48}, SH ? 64'h8000_0000_0000 : 64'd0);
    step();

    // Stall with out_ready low for 5 cycles and 3 operands offered.
    r8  = 0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      v8 = (idx < 3);
      d8 = st8[(idx < 3) ? idx : 0];
      @(negedge clk);
      if (c >= 2) begin
        chk("stall in_ready", {63'd0, rdy8}, 64'd0);
        chk("stall lzc", {60'd0, ol8}, 64'd1);
        chk("stall norm", {56'd0, on8}, SH ? 64'h80 : 64'd0);
      end
      acc = v8 && rdy8;
      step();
      if (acc) idx++;
    end
    chk("stall accepted", idx, 64'd2);
    r8 = 1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      v8 = 1;
      d8 = st8[idx];
      @(negedge clk);
      acc = rdy8;
      step();
      if (acc) idx++;
    end
    v8 = 0;
    chk("stall release", idx, 64'd3);
    for (int c = 0; c < 10 && q8.size() > 0; c++) step();
    chk("stall drain", q8.size(), 64'd0);

    // Reset with two operands in flight.
    v8 = 1;
    d8 = 8'h20;
    step();
    d8 = 8'h00;
    step();
    v8  = 0;
    rst = 1;
    step();
    rst = 0;
    v8  = 1;
    d8  = 8'h02;
    @(negedge clk);
    chk("rst out_valid", {63'd0, ov8}, 64'd0);
    chk("rst zero_cnt", {48'd0, zc8}, 64'd0);
    step();
    v8 = 0;
    @(negedge clk);
    chk("rst no stale", {63'd0, ov8}, 64'd0);
    step();
    @(negedge clk);
    chk("rst new valid", {63'd0, ov8}, 64'd1);
    chk("rst new lzc", {60'd0, ol8}, 64'd6);
    step();

    // Saturation of the zero counter.
    v8 = 1;
    d8 = 8'h00;
    for (int n = 0; n < 65535; n++) begin
      if (n == 65534) begin
        @(negedge clk);
        chk("sat near", {48'd0, zc8}, 64'hFFFE);
      end
      step();
    end
    @(negedge clk);
    chk("sat full", {48'd0, zc8}, 64'hFFFF);
    for (int n = 0; n < 3; n++) step();
    v8 = 0;
    @(negedge clk);
    chk("sat hold", {48'd0, zc8}, 64'hFFFF);

    for (int c = 0; c < 10 && (q8.size() > 0 || q48.size() > 0); c++) step();
    chk("final drain", q8.size() + q48.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
